decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/decode_comb.sv | 203 ++++++++++++++++++++
 rtl/decode_stage.sv | 99 +++++++++
 tb/tb_decode_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V decode types: opcodes, ALU ops, memory sizes, decoded uop
// Ports: none (package). Imported by decode_comb and decode_stage.
package riscv_pkg;

    // Widest supported datapath; imm and pc fields are sized for it so one
    // struct type serves both XLEN=32 and XLEN=64 builds.
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;
    localparam logic [1:0] MEM_D = 2'd3;

    // ALU_ADD is encoding 0 so an all-zero uop decodes as a harmless add.
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_MUL, ALU_MULH, ALU_MULHSU,
        ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY, ST_ONE, ST_FULL
    } skid_state_e;

    // imm is sign-extended across all XLEN_MAX bits; pc is zero-extended.
    typedef struct packed {
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic                rd_v;
        logic                rs1_v;
        logic                rs2_v;
        logic [XLEN_MAX-1:0] imm;
        alu_op_e             alu_op;
        logic                is_load;
        logic                is_store;
        logic                is_branch;
        logic                is_jump;
        logic [1:0]          mem_size;
        logic                mem_unsigned;
        logic                is_word_op;
        logic                illegal;
        logic [XLEN_MAX-1:0] pc;
        logic [31:0]         instr;
    } decoded_uop_t;

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - purely combinational RV32I/RV64I(+M) instruction decoder
// Ports: instr (32-bit word), pc (XLEN) -> uop (decoded_uop_t).
module decode_comb
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output decoded_uop_t    uop
);

    localparam logic IS64  = (XLEN == 64);
    localparam logic HAS_M = (M_EXT != 0);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt6, shamt5;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i  = {{52{instr[31]}}, instr[31:20]};
    assign imm_s  = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j  = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt6 = {58'b0, instr[25:20]};
    assign shamt5 = {59'b0, instr[24:20]};

    logic rd_w, rs1_u, rs2_u, bad;

    always_comb begin
        uop       = '0;
        rd_w      = 1'b0;
        rs1_u     = 1'b0;
        rs2_u     = 1'b0;
        bad       = 1'b0;
        uop.rd    = instr[11:7];
        uop.rs1   = instr[19:15];
        uop.rs2   = instr[24:20];
        uop.pc    = 64'(pc);
        uop.instr = instr;
        uop.alu_op = ALU_ADD;

        case (opcode)
            OPC_LUI: begin
                rd_w = 1'b1; uop.imm = imm_u; uop.alu_op = ALU_LUI;
            end
            OPC_AUIPC: begin
                rd_w = 1'b1; uop.imm = imm_u;
            end
            OPC_JAL: begin
                rd_w = 1'b1; uop.imm = imm_j; uop.is_jump = 1'b1;
            end
            OPC_JALR: begin
                rd_w = 1'b1; rs1_u = 1'b1; uop.imm = imm_i; uop.is_jump = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                rs1_u = 1'b1; rs2_u = 1'b1; uop.imm = imm_b; uop.is_branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   uop.alu_op = ALU_SUB;
                    2'b10:   uop.alu_op = ALU_SLT;
                    2'b11:   uop.alu_op = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                rd_w = 1'b1; rs1_u = 1'b1; uop.imm = imm_i; uop.is_load = 1'b1;
                uop.mem_size = funct3[1:0]; uop.mem_unsigned = funct3[2];
                case (funct3)
                    3'b011, 3'b110: bad = !IS64;   // LD, LWU
                    3'b111:         bad = 1'b1;
                    default:        bad = 1'b0;
                endcase
            end
            OPC_STORE: begin
                rs1_u = 1'b1; rs2_u = 1'b1; uop.imm = imm_s; uop.is_store = 1'b1;
                uop.mem_size = funct3[1:0];
                if (funct3[2])                bad = 1'b1;
                else if (funct3[1:0] == MEM_D) bad = !IS64;
            end
            OPC_OP_IMM: begin
                rd_w = 1'b1; rs1_u = 1'b1; uop.imm = imm_i;
                case (funct3)
                    3'b000: uop.alu_op = ALU_ADD;
                    3'b010: uop.alu_op = ALU_SLT;
                    3'b011: uop.alu_op = ALU_SLTU;
                    3'b100: uop.alu_op = ALU_XOR;
                    3'b110: uop.alu_op = ALU_OR;
                    3'b111: uop.alu_op = ALU_AND;
                    3'b001: begin
                        uop.alu_op = ALU_SLL; uop.imm = shamt6;
                        bad = (instr[31:26] != 6'b000000) || (instr[25] && !IS64);
                    end
                    default: begin  // 3'b101: shamt[5] lives in instr[25]
                        uop.imm = shamt6;
                        if (instr[31:26] == 6'b000000)      uop.alu_op = ALU_SRL;
                        else if (instr[31:26] == 6'b010000) uop.alu_op = ALU_SRA;
                        else                                bad = 1'b1;
                        if (instr[25] && !IS64) bad = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                rd_w = 1'b1; rs1_u = 1'b1; rs2_u = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  uop.alu_op = ALU_ADD;
                            3'b001:  uop.alu_op = ALU_SLL;
                            3'b010:  uop.alu_op = ALU_SLT;
                            3'b011:  uop.alu_op = ALU_SLTU;
                            3'b100:  uop.alu_op = ALU_XOR;
                            3'b101:  uop.alu_op = ALU_SRL;
                            3'b110:  uop.alu_op = ALU_OR;
                            default: uop.alu_op = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      uop.alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) uop.alu_op = ALU_SRA;
                        else                       bad = 1'b1;
                    end
                    7'b0000001: begin
                        bad = !HAS_M;
                        case (funct3)
                            3'b000:  uop.alu_op = ALU_MUL;
                            3'b001:  uop.alu_op = ALU_MULH;
                            3'b010:  uop.alu_op = ALU_MULHSU;
                            3'b011:  uop.alu_op = ALU_MULHU;
                            3'b100:  uop.alu_op = ALU_DIV;
                            3'b101:  uop.alu_op = ALU_DIVU;
                            3'b110:  uop.alu_op = ALU_REM;
                            default: uop.alu_op = ALU_REMU;
                        endcase
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP_IMM_32: begin
                rd_w = 1'b1; rs1_u = 1'b1; uop.is_word_op = 1'b1; uop.imm = shamt5;
                case (funct3)
                    3'b000: uop.imm = imm_i;
                    3'b001: begin
                        uop.alu_op = ALU_SLL; bad = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000)      uop.alu_op = ALU_SRL;
                        else if (funct7 == 7'b0100000) uop.alu_op = ALU_SRA;
                        else                           bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
                if (!IS64) bad = 1'b1;
            end
            OPC_OP_32: begin
                rd_w = 1'b1; rs1_u = 1'b1; rs2_u = 1'b1; uop.is_word_op = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: uop.alu_op = ALU_ADD;
                    {7'b0000000, 3'b001}: uop.alu_op = ALU_SLL;
                    {7'b0000000, 3'b101}: uop.alu_op = ALU_SRL;
                    {7'b0100000, 3'b000}: uop.alu_op = ALU_SUB;
                    {7'b0100000, 3'b101}: uop.alu_op = ALU_SRA;
                    {7'b0000001, 3'b000}: begin uop.alu_op = ALU_MUL;  bad = !HAS_M; end
                    {7'b0000001, 3'b100}: begin uop.alu_op = ALU_DIV;  bad = !HAS_M; end
                    {7'b0000001, 3'b101}: begin uop.alu_op = ALU_DIVU; bad = !HAS_M; end
                    {7'b0000001, 3'b110}: begin uop.alu_op = ALU_REM;  bad = !HAS_M; end
                    {7'b0000001, 3'b111}: begin uop.alu_op = ALU_REMU; bad = !HAS_M; end
                    default: bad = 1'b1;
                endcase
                if (!IS64) bad = 1'b1;
            end
            OPC_MISC_MEM: begin
                // FENCE / FENCE.I: no register traffic
                bad = (funct3[2:1] != 2'b00);
            end
            OPC_SYSTEM: begin
                // Only ECALL and EBREAK are decoded; CSR access is not supported here
                bad = (instr != 32'h0000_0073) && (instr != 32'h0010_0073);
            end
            default: bad = 1'b1;
        endcase

        // An illegal uop still issues, but must not touch registers or memory
        if (bad) begin
            uop.illegal    = 1'b1;
            uop.is_load    = 1'b0;
            uop.is_store   = 1'b0;
            uop.is_branch  = 1'b0;
            uop.is_jump    = 1'b0;
            uop.is_word_op = 1'b0;
        end
        uop.rd_v  = rd_w && (instr[11:7] != 5'd0) && !bad;
        uop.rs1_v = rs1_u && !bad;
        uop.rs2_v = rs2_u && !bad;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with 2-entry skid buffer and illegal counter
// Ports: clk_i, rst_i (sync active-high), valid_i/ready_o/instr_i/pc_i (fetch side),
//        flush_i, valid_o/ready_i/uop_o (issue side), illegal_cnt_o (saturating count).
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output decoded_uop_t     uop_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    decoded_uop_t dec_uop;
    decoded_uop_t skid_uop;
    skid_state_e  state, state_nxt;
    logic         in_xfer, out_xfer;
    logic         load_head_dec, load_head_skid, load_skid;

    decode_comb #(
        .XLEN  (XLEN),
        .M_EXT (M_EXT)
    ) u_decode_comb (
        .instr (instr_i),
        .pc    (pc_i),
        .uop   (dec_uop)
    );

    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;
    assign valid_o  = (state != ST_EMPTY);

    // uop_o is the head entry; skid_uop holds the second entry only in FULL
    always_comb begin
        state_nxt      = state;
        load_head_dec  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_nxt     = ST_ONE;
                        load_head_dec = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_head_dec = 1'b1;
                    end else if (in_xfer) begin
                        state_nxt = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so no input can arrive alongside
                    if (out_xfer) begin
                        state_nxt      = ST_ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_EMPTY;
            ready_o       <= 1'b1;
            uop_o         <= '0;
            skid_uop      <= '0;
            illegal_cnt_o <= '0;
        end else begin
            state   <= state_nxt;
            ready_o <= (state_nxt != ST_FULL);
            if (load_head_dec)       uop_o <= dec_uop;
            else if (load_head_skid) uop_o <= skid_uop;
            if (load_skid)           skid_uop <= dec_uop;
            if (out_xfer && uop_o.illegal && (illegal_cnt_o != '1))
                illegal_cnt_o <= illegal_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage (RV32/no-M and RV64/M builds)
module tb_decode_stage;
    import riscv_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0;
    logic [31:0]  instr = 32'h0000_0013;
    logic [63:0]  pc = 64'h0;
    logic         flush = 1'b0;
    logic         ready_i = 1'b1;

    logic         ready32, valid32, ready64, valid64;
    decoded_uop_t uop32, uop64;
    logic [1:0]   cnt32;
    logic [15:0]  cnt64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .M_EXT(0), .CNT_W(2)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready32),
        .instr_i(instr), .pc_i(pc[31:0]), .flush_i(flush), .valid_o(valid32),
        .ready_i(ready_i), .uop_o(uop32), .illegal_cnt_o(cnt32)
    );

    decode_stage #(.XLEN(64), .M_EXT(1), .CNT_W(16)) dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready64),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .valid_o(valid64),
        .ready_i(ready_i), .uop_o(uop64), .illegal_cnt_o(cnt64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for one cycle; the uop is in uop_o on return
    task automatic issue(input logic [31:0] word, input logic [63:0] addr);
        valid_i = 1'b1;
        instr   = word;
        pc      = addr;
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
        tick(); tick();
        check("rst_valid32", valid32, 0);
        check("rst_ready32", ready32, 1);
        check("rst_cnt32",   cnt32, 0);
        check("rst_uop32",   |uop32, 0);
        check("rst_uop64",   |uop64, 0);
        rst = 1'b0;
        tick();

        // addi x1,x0,5
        issue(32'h0050_0093, 64'h100);
        check("addi_valid", valid32, 1);
        check("addi_rd",    uop32.rd, 1);
        check("addi_rs1",   uop32.rs1, 0);
        check("addi_imm",   uop32.imm[31:0], 5);
        check("addi_alu",   uop32.alu_op, ALU_ADD);
        check("addi_rd_v",  uop32.rd_v, 1);
        check("addi_ill",   uop32.illegal, 0);
        check("addi_pc",    uop32.pc[31:0], 32'h100);
        tick();
        check("addi_drain", valid32, 0);

        // srai x2,x3,4
        issue(32'h4041_D113, 64'h104);
        check("srai_alu32", uop32.alu_op, ALU_SRA);
        check("srai_imm",   uop32.imm[4:0], 4);
        check("srai_rd",    uop32.rd, 2);
        check("srai_rs1",   uop32.rs1, 3);
        check("srai_alu64", uop64.alu_op, ALU_SRA);
        tick();

        // mul x0,x1,x2: illegal without M, legal with M but rd=x0
        issue(32'h0220_8033, 64'h108);
        check("mul_ill32",  uop32.illegal, 1);
        check("mul_rdv32",  uop32.rd_v, 0);
        check("mul_rs1v32", uop32.rs1_v, 0);
        check("mul_cnt_pre", cnt32, 0);
        check("mul_ill64",  uop64.illegal, 0);
        check("mul_alu64",  uop64.alu_op, ALU_MUL);
        check("mul_rdv64",  uop64.rd_v, 0);
        tick();
        check("mul_cnt_post", cnt32, 1);
        check("mul_cnt64",    cnt64, 0);

        // ld x5,0(x6)
        issue(32'h0003_3283, 64'h10C);
        check("ld_ill32",  uop32.illegal, 1);
        check("ld_rdv32",  uop32.rd_v, 0);
        check("ld_ill64",  uop64.illegal, 0);
        check("ld_load64", uop64.is_load, 1);
        check("ld_size64", uop64.mem_size, MEM_D);
        check("ld_rd64",   uop64.rd, 5);
        tick();
        check("ld_cnt32", cnt32, 2);

        // slli x1,x1,32: shamt[5] set
        issue(32'h0200_9093, 64'h110);
        check("slli32_ill", uop32.illegal, 1);
        check("slli64_ill", uop64.illegal, 0);
        check("slli64_alu", uop64.alu_op, ALU_SLL);
        check("slli64_imm", uop64.imm, 32);
        tick();
        check("slli_cnt32", cnt32, 3);

        // sw x2,4(x1)
        issue(32'h0020_A223, 64'h114);
        check("sw_store", uop32.is_store, 1);
        check("sw_rdv",   uop32.rd_v, 0);
        check("sw_rs2v",  uop32.rs2_v, 1);
        check("sw_imm",   uop32.imm[31:0], 4);
        check("sw_size",  uop32.mem_size, MEM_W);
        tick();

        // beq x0,x0,-4
        issue(32'hFE00_0EE3, 64'h118);
        check("beq_branch", uop64.is_branch, 1);
        check("beq_rdv",    uop64.rd_v, 0);
        check("beq_imm64",  uop64.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_imm32",  uop32.imm[31:0], 32'hFFFF_FFFC);
        tick();

        // lui x1,0x80000: U-type sign extension from bit 31
        issue(32'h8000_00B7, 64'h11C);
        check("lui_imm64", uop64.imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_alu",   uop64.alu_op, ALU_LUI);
        tick();

        // funct7=0100000 on SLL: undefined pattern, counter saturates on dut32
        issue(32'h4000_1033, 64'h120);
        check("badf7_ill32", uop32.illegal, 1);
        check("badf7_ill64", uop64.illegal, 1);
        check("badf7_rdv64", uop64.rd_v, 0);
        tick();
        check("sat_cnt32", cnt32, 3);
        check("badf7_cnt64", cnt64, 1);

        // Back-pressure: three offered, two accepted, order preserved
        ready_i = 1'b0;
        valid_i = 1'b1;
        instr = 32'h0050_0093;          // addi x1
        tick();
        check("skid_a_ready", ready32, 1);
        check("skid_a_rd",    uop32.rd, 1);
        instr = 32'h0060_0113;          // addi x2
        tick();
        check("skid_full_ready", ready32, 0);
        check("skid_full_valid", valid32, 1);
        instr = 32'h0070_0193;          // addi x3
        tick();
        check("skid_hold_rd",    uop32.rd, 1);
        check("skid_hold_ready", ready32, 0);
        ready_i = 1'b1;
        tick();
        check("skid_out2_rd", uop32.rd, 2);
        check("skid_ready_back", ready32, 1);
        tick();
        check("skid_out3_rd", uop32.rd, 3);
        check("skid_out3_imm", uop32.imm[31:0], 7);
        valid_i = 1'b0;
        tick();
        check("skid_drained", valid32, 0);

        // Flush in FULL with valid_i high
        ready_i = 1'b0;
        valid_i = 1'b1;
        instr = 32'h0050_0093;
        tick();
        instr = 32'h0060_0113;
        tick();
        check("fl_full_ready", ready32, 0);
        instr = 32'h0070_0193;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        valid_i = 1'b0;
        check("fl_full_valid", valid32, 0);
        check("fl_full_ready1", ready32, 1);
        check("fl_full_valid64", valid64, 0);

        // Flush in ONE drops the same-cycle input transfer
        valid_i = 1'b1;
        instr = 32'h0050_0093;
        tick();
        instr = 32'h0070_0193;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        valid_i = 1'b0;
        check("fl_one_valid", valid32, 0);
        tick();
        check("fl_one_stay_empty", valid32, 0);
        ready_i = 1'b1;
        issue(32'h0040_0213, 64'h200);  // addi x4,x0,4
        check("fl_next_rd", uop32.rd, 4);
        check("fl_next_pc", uop32.pc[31:0], 32'h200);

        // Reset mid-operation with an entry buffered and a saturated counter
        ready_i = 1'b0;
        issue(32'h4000_1033, 64'h204);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", valid32, 0);
        check("mrst_ready", ready32, 1);
        check("mrst_cnt32", cnt32, 0);
        check("mrst_cnt64", cnt64, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
